spi_master_xfer: RTL and testbench

- SPI mode-0 master: the initiator end of the SPI link, driving SPI_CLK, SPI_MOSI and SPI_SS and sampling SPI_MISO.
- Sends a packet of N bytes (command byte first, then payload) pulled from a valid/ready byte stream.
- Returns every byte shifted in on MISO as a one-cycle rxValid strobe.
- Drives the slave-under-test in the system-level bench and serves as an RTL host port for on-chip register/memory access over SPI.

---
 rtl/spi_master_xfer.sv | 160 ++++++++++++++++
 tb/tb_spi_master_xfer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer.sv
// SPI mode-0 master that sends a packet of bytes taken from a valid/ready stream.
// Every byte shifted in on MISO is returned as a one-cycle rxValid strobe.
module spi_master_xfer #(
    parameter int ClkDiv  = 2,
    parameter int CsSetup = 2,
    parameter int CsHold  = 2,
    parameter int LenBits = 12
) (
    input  logic               SysClk,
    input  logic               Reset,
    input  logic               start,
    input  logic [LenBits-1:0] xferLen,
    input  logic               abort,
    input  logic [7:0]         txData,
    input  logic               txValid,
    output logic               txReady,
    output logic [7:0]         rxData,
    output logic               rxValid,
    output logic               busy,
    output logic               done,
    output logic               SPI_CLK,
    output logic               SPI_MOSI,
    output logic               SPI_SS,
    input  logic               SPI_MISO
);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, LOW, HIGH, HOLD, GAP} state_t;

    // HOLD counts 0..CsHold, so the counter must also reach CsHold.
    localparam int CntMax0 = (ClkDiv > CsSetup) ? ClkDiv : CsSetup;
    localparam int CntMax  = (CntMax0 > CsHold + 1) ? CntMax0 : CsHold + 1;
    localparam int CntW    = $clog2(CntMax + 1);

    state_t             state;
    logic [CntW-1:0]    cnt;
    logic [2:0]         bit_cnt;
    logic [LenBits-1:0] remaining;
    logic [7:0]         tx_shift;
    logic [7:0]         rx_shift;

    // NOTE: every register here is assigned with <= so that all of them update
    // together from values sampled before the edge.
    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            SPI_SS    <= 1'b1;
            SPI_CLK   <= 1'b0;
            SPI_MOSI  <= 1'b0;
            txReady   <= 1'b0;
            rxValid   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rxData    <= 8'h00;
        end else begin
            rxValid <= 1'b0;
            done    <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= GAP;
                cnt      <= '0;
                SPI_SS   <= 1'b1;
                SPI_CLK  <= 1'b0;
                SPI_MOSI <= 1'b0;
                txReady  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && xferLen != '0) begin
                            remaining <= xferLen;
                            SPI_SS    <= 1'b0;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            state     <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (cnt == CntW'(CsSetup - 1)) begin
                            cnt     <= '0;
                            txReady <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOAD: begin
                        if (txValid) begin
                            tx_shift <= txData;
                            SPI_MOSI <= txData[7];
                            bit_cnt  <= '0;
                            txReady  <= 1'b0;
                            cnt      <= '0;
                            state    <= LOW;
                        end
                    end
                    LOW: begin
                        if (cnt == CntW'(ClkDiv - 1)) begin
                            cnt      <= '0;
                            SPI_CLK  <= 1'b1;
                            rx_shift <= {rx_shift[6:0], SPI_MISO};
                            state    <= HIGH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt == CntW'(ClkDiv - 1)) begin
                            cnt     <= '0;
                            SPI_CLK <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                SPI_MOSI <= tx_shift[6];
                                bit_cnt  <= bit_cnt + 3'd1;
                                state    <= LOW;
                            end else begin
                                // rx_shift already holds all 8 bits; the 8th was taken on the last rise.
                                rxData    <= rx_shift;
                                rxValid   <= 1'b1;
                                remaining <= remaining - 1'b1;
                                if (remaining != LenBits'(1)) begin
                                    txReady <= 1'b1;
                                    state   <= LOAD;
                                end else begin
                                    state <= HOLD;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt == CntW'(CsHold)) begin
                            cnt      <= '0;
                            SPI_SS   <= 1'b1;
                            SPI_MOSI <= 1'b0;
                            done     <= 1'b1;
                            state    <= GAP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == CntW'(ClkDiv - 1)) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: a mode-0 slave model, a per-cycle
// protocol model checked at the falling SysClk edge, and literal per-test counts.
`timescale 1ns/1ps
module tb_spi_master_xfer;

    localparam int ClkDiv  = 2;
    localparam int CsSetup = 2;
    localparam int CsHold  = 2;
    localparam int LenBits = 12;
    localparam int Budget  = 2000;

    logic               SysClk = 1'b0;
    logic               Reset = 1'b0;
    logic               start = 1'b0;
    logic [LenBits-1:0] xferLen = '0;
    logic               abort = 1'b0;
    logic [7:0]         txData = 8'h00;
    logic               txValid = 1'b0;
    logic               txReady;
    logic [7:0]         rxData;
    logic               rxValid;
    logic               busy;
    logic               done;
    logic               SPI_CLK;
    logic               SPI_MOSI;
    logic               SPI_SS;
    logic               SPI_MISO;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_bytes[4];
    logic [7:0] slave_bytes[4];

    // Observation counters, written only by the compare process.
    int         rise_cnt = 0, rx_cnt = 0, hs_cnt = 0, done_cnt = 0;
    logic [7:0] last_mosi = 8'h00, last_rx = 8'h00;
    int         b_rise, b_rx, b_hs, b_done;

    spi_master_xfer #(
        .ClkDiv (ClkDiv),
        .CsSetup(CsSetup),
        .CsHold (CsHold),
        .LenBits(LenBits)
    ) dut (
        .SysClk  (SysClk),
        .Reset   (Reset),
        .start   (start),
        .xferLen (xferLen),
        .abort   (abort),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady),
        .rxData  (rxData),
        .rxValid (rxValid),
        .busy    (busy),
        .done    (done),
        .SPI_CLK (SPI_CLK),
        .SPI_MOSI(SPI_MOSI),
        .SPI_SS  (SPI_SS),
        .SPI_MISO(SPI_MISO)
    );

    always #5 SysClk = ~SysClk;

    // Mode-0 slave: presents bit 7 while selected and advances on every SPI_CLK fall.
    logic [4:0] fall_cnt = '0;
    logic [7:0] slave_cur;
    always @(negedge SPI_CLK or posedge SPI_SS) begin
        if (SPI_SS) fall_cnt <= '0;
        else        fall_cnt <= fall_cnt + 5'd1;
    end
    always_comb begin
        slave_cur = slave_bytes[fall_cnt[4:3]];
        SPI_MISO  = SPI_SS ? 1'b0 : slave_cur[3'd7 - fall_cnt[2:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model, evaluated once per cycle on the falling SysClk edge.
    logic [7:0] exp_tx[$];
    initial begin : compare
        int   bit_n, lvl, rx_idx, cur_len, done_in, gap_in, setup_in;
        logic clk_prev, byte_done, abort_pend, rise, fall, abort_now, exp_rxv;
        logic [7:0] mosi_sr;
        bit_n = 0; lvl = 0; rx_idx = 0; cur_len = 0;
        done_in = -1; gap_in = -1; setup_in = -1;
        clk_prev = 1'b0; byte_done = 1'b0; abort_pend = 1'b0; mosi_sr = 8'h00;
        forever begin
            @(negedge SysClk);
            if (!Reset) begin
                exp_tx.delete();
                bit_n = 0; lvl = 0; rx_idx = 0; cur_len = 0;
                done_in = -1; gap_in = -1; setup_in = -1;
                clk_prev = 1'b0; byte_done = 1'b0; abort_pend = 1'b0;
            end else begin
                rise      = SPI_CLK && !clk_prev;
                fall      = !SPI_CLK && clk_prev;
                abort_now = abort_pend;
                if (abort_pend) begin
                    check("abort_ss", SPI_SS, 1);
                    check("abort_clk", SPI_CLK, 0);
                    check("abort_mosi", SPI_MOSI, 0);
                    check("abort_txready", txReady, 0);
                    check("abort_done", done, 0);
                    exp_tx.delete();
                    bit_n = 0; byte_done = 1'b0;
                    done_in = -1; setup_in = -1; gap_in = ClkDiv;
                    abort_pend = 1'b0;
                end else begin
                    if (gap_in > 0) begin
                        gap_in--;
                        if (gap_in > 0) begin
                            check("gap_busy", busy, 1);
                            check("gap_ss", SPI_SS, 1);
                        end else begin
                            check("gap_end_busy", busy, 0);
                            gap_in = -1;
                        end
                    end
                    if (done_in > 0) done_in--;
                    check("done", done, done_in == 0);
                    if (done_in == 0) begin
                        check("done_ss", SPI_SS, 1);
                        done_in = -1;
                        gap_in  = ClkDiv;
                    end
                    if (setup_in > 0) begin
                        setup_in--;
                        if (setup_in == CsSetup) begin
                            check("start_busy", busy, 1);
                            check("start_ss", SPI_SS, 0);
                        end
                        check("setup_txready", txReady, setup_in == 0);
                        if (setup_in == 0) setup_in = -1;
                    end
                end

                if (rise) begin
                    rise_cnt++;
                    check("ss_at_rise", SPI_SS, 0);
                    if (bit_n > 0) check("low_len", lvl, ClkDiv);
                    mosi_sr = {mosi_sr[6:0], SPI_MOSI};
                    bit_n++;
                    if (bit_n == 8) begin
                        bit_n     = 0;
                        byte_done = 1'b1;
                        last_mosi = mosi_sr;
                        check("tx_pending", exp_tx.size() != 0, 1);
                        if (exp_tx.size() != 0) check("mosi_byte", mosi_sr, exp_tx.pop_front());
                    end
                end
                if (fall && !abort_now) check("high_len", lvl, ClkDiv);
                exp_rxv = fall && byte_done && !abort_now;
                check("rx_valid", rxValid, exp_rxv);
                if (rxValid) begin
                    rx_cnt++;
                    last_rx = rxData;
                    check("rx_data", rxData, slave_bytes[rx_idx]);
                    rx_idx++;
                    if (rx_idx == cur_len) done_in = CsHold + 1;
                end
                if (fall) byte_done = 1'b0;
                lvl      = (SPI_CLK != clk_prev) ? 1 : lvl + 1;
                clk_prev = SPI_CLK;
                if (done) done_cnt++;

                check("clk_while_deselected", SPI_SS && SPI_CLK, 0);
                check("idle_outputs", !busy && (!SPI_SS || SPI_MOSI || txReady), 0);
                check("load_quiet", txReady && (SPI_CLK || SPI_SS), 0);

                if (abort && busy) begin
                    abort_pend = 1'b1;
                end else if (txValid && txReady) begin
                    exp_tx.push_back(txData);
                    hs_cnt++;
                end
                if (start && !busy && xferLen != '0) begin
                    setup_in = CsSetup + 1;
                    cur_len  = int'(xferLen);
                    rx_idx   = 0;
                end
            end
        end
    end

    task automatic mark();
        b_rise = rise_cnt; b_rx = rx_cnt; b_hs = hs_cnt; b_done = done_cnt;
    endtask

    task automatic expect_counts(input string tag, input int rises, input int rxs, input int hss, input int dones);
        check({tag, "_rises"}, rise_cnt - b_rise, rises);
        check({tag, "_rxvalid"}, rx_cnt - b_rx, rxs);
        check({tag, "_handshakes"}, hs_cnt - b_hs, hss);
        check({tag, "_done"}, done_cnt - b_done, dones);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ss"}, SPI_SS, 1);
        check({tag, "_clk"}, SPI_CLK, 0);
        check({tag, "_mosi"}, SPI_MOSI, 0);
        check({tag, "_txready"}, txReady, 0);
        check({tag, "_rxvalid"}, rxValid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rxdata"}, rxData, 8'h00);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_xfer(input int len, input int stall_at, input int stall_cyc,
                            input int abort_rise, input int restart_at);
        int   idx, hold, rises, cyc;
        logic prev_clk, seen, aborted, hs;
        idx = 0; hold = 0; rises = 0;
        prev_clk = 1'b0; seen = 1'b0; aborted = 1'b0;
        start   = 1'b1;
        xferLen = LenBits'(len);
        @(posedge SysClk); #1;
        start   = 1'b0;
        xferLen = '0;
        for (cyc = 0; cyc < Budget; cyc++) begin
            if (busy) seen = 1'b1;
            if (seen && !busy) break;
            txValid = (idx < len) && (hold == 0);
            txData  = txValid ? tx_bytes[idx] : 8'h00;
            abort   = (abort_rise > 0) && !aborted && (rises == abort_rise);
            if (abort) aborted = 1'b1;
            if (cyc == restart_at) begin
                start   = 1'b1;
                xferLen = LenBits'(5);
            end
            hs = txValid && txReady;
            @(posedge SysClk); #1;
            abort   = 1'b0;
            start   = 1'b0;
            xferLen = '0;
            if (SPI_CLK && !prev_clk) rises++;
            prev_clk = SPI_CLK;
            if (hold > 0) hold--;
            if (hs) begin
                idx++;
                if (idx == stall_at) hold = stall_cyc;
            end
        end
        txValid = 1'b0;
        txData  = 8'h00;
        check("xfer_finished", busy, 0);
        repeat (3) @(posedge SysClk);
        #1;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int ss_low;
        for (int i = 0; i < 4; i++) begin
            tx_bytes[i]    = 8'h00;
            slave_bytes[i] = 8'h00;
        end
        repeat (3) @(posedge SysClk);
        #1;
        check_reset("por");
        Reset = 1'b1;
        repeat (2) @(posedge SysClk);
        #1;

        // Single byte 0x03 out, slave answers 0xA5.
        tx_bytes[0] = 8'h03; slave_bytes[0] = 8'hA5;
        mark();
        run_xfer(1, -1, 0, 0, -1);
        expect_counts("one_byte", 8, 1, 1, 1);
        check("one_byte_mosi", last_mosi, 8'h03);
        check("one_byte_rx", last_rx, 8'hA5);
        check("one_byte_rxdata", rxData, 8'hA5);

        // Three-byte packet.
        tx_bytes[0] = 8'h81; tx_bytes[1] = 8'h12; tx_bytes[2] = 8'h34;
        slave_bytes[0] = 8'h3C; slave_bytes[1] = 8'hC3; slave_bytes[2] = 8'h7E;
        mark();
        run_xfer(3, -1, 0, 0, -1);
        expect_counts("three_bytes", 24, 3, 3, 1);
        check("three_bytes_mosi", last_mosi, 8'h34);
        check("three_bytes_rx", last_rx, 8'h7E);

        // txValid withheld for 20 cycles before the second byte.
        tx_bytes[0] = 8'hE7; tx_bytes[1] = 8'h19;
        slave_bytes[0] = 8'h55; slave_bytes[1] = 8'hAA;
        mark();
        run_xfer(2, 1, 20, 0, -1);
        expect_counts("stall", 16, 2, 2, 1);
        check("stall_mosi", last_mosi, 8'h19);
        check("stall_rx", last_rx, 8'hAA);

        // Abort on the 4th rise of the first byte, then a clean transfer.
        tx_bytes[0] = 8'hF0; tx_bytes[1] = 8'h0F;
        slave_bytes[0] = 8'hFF; slave_bytes[1] = 8'h00;
        mark();
        run_xfer(2, -1, 0, 4, -1);
        expect_counts("abort", 4, 0, 1, 0);
        tx_bytes[0] = 8'hC5; slave_bytes[0] = 8'h99;
        mark();
        run_xfer(1, -1, 0, 0, -1);
        expect_counts("after_abort", 8, 1, 1, 1);
        check("after_abort_mosi", last_mosi, 8'hC5);
        check("after_abort_rx", last_rx, 8'h99);

        // start with zero length is ignored.
        mark();
        ss_low  = 0;
        start   = 1'b1;
        xferLen = '0;
        @(posedge SysClk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!SPI_SS || busy) ss_low++;
            @(posedge SysClk); #1;
        end
        check("zero_len_activity", ss_low, 0);
        expect_counts("zero_len", 0, 0, 0, 0);

        // A second start while busy is ignored.
        tx_bytes[0] = 8'h6B; slave_bytes[0] = 8'h42;
        mark();
        run_xfer(1, -1, 0, 0, 10);
        expect_counts("start_busy", 8, 1, 1, 1);
        check("start_busy_rx", last_rx, 8'h42);

        // Reset asserted mid-byte, then a clean transfer.
        tx_bytes[0] = 8'h77; slave_bytes[0] = 8'h11;
        start   = 1'b1;
        xferLen = LenBits'(1);
        @(posedge SysClk); #1;
        start   = 1'b0;
        xferLen = '0;
        txValid = 1'b1;
        txData  = 8'h77;
        repeat (12) @(posedge SysClk);
        #1;
        check("pre_reset_busy", busy, 1);
        #2;
        Reset = 1'b0;
        #1;
        check_reset("mid_reset");
        txValid = 1'b0;
        txData  = 8'h00;
        repeat (2) @(posedge SysClk);
        #1;
        Reset = 1'b1;
        repeat (2) @(posedge SysClk);
        #1;
        tx_bytes[0] = 8'h5A; slave_bytes[0] = 8'h24;
        mark();
        run_xfer(1, -1, 0, 0, -1);
        expect_counts("post_reset", 8, 1, 1, 1);
        check("post_reset_mosi", last_mosi, 8'h5A);
        check("post_reset_rx", last_rx, 8'h24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
